// File: rtl/cpu_pkg.sv
// Shared fetch-path types and default widths for the instruction fetch unit.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; pointers carry an extra MSB so full and
// empty are told apart without a separate count register.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_ADDR_W + CPU_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [DATA_W-1:0]             head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[PW-1:0]];
  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != DEPTH_L) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage is data only; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: one-outstanding-request memory FSM feeding a prefetch FIFO,
// with redirect flush. Optional stall counter enabled by FETCH_PERF_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter int                DATA_W     = CPU_DATA_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [ADDR_W-1:0]             imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [DATA_W-1:0]             imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [DATA_W-1:0]             instr_data,
  output logic [ADDR_W-1:0]             instr_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]                   perf_stall_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int            LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_addr_nxt;
  logic              drop;
  logic              drop_nxt;
  logic              push;
  logic              pop;
  logic              flush;
  logic [LW-1:0]     level_after;
  logic [ADDR_W+DATA_W-1:0] head;

  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = req_addr;
  assign instr_valid    = (fifo_level != '0);
  assign instr_data     = head[ADDR_W+DATA_W-1:ADDR_W];
  assign instr_pc       = head[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FS_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
      drop     <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_addr_nxt = req_addr;
    drop_nxt     = drop;
    push         = 1'b0;
    flush        = redirect_valid;
    pop          = instr_valid && instr_ready && !redirect_valid;
    level_after  = fifo_level;
    case (state)
      FS_IDLE: begin
        if (redirect_valid) begin
          state_nxt    = FS_REQ;
          fetch_pc_nxt = redirect_pc;
          req_addr_nxt = redirect_pc;
        end else if (fifo_level < DEPTH_L) begin
          state_nxt    = FS_REQ;
          req_addr_nxt = fetch_pc;
        end
      end
      FS_REQ: begin
        // The presented address stays put; only the next request sees the new pc.
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          drop_nxt     = 1'b1;
        end
        if (imem_req_ready) state_nxt = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_rsp_valid) begin
          drop_nxt = 1'b0;
          if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc;
            req_addr_nxt = redirect_pc;
            state_nxt    = FS_REQ;
          end else begin
            if (!drop) begin
              push         = 1'b1;
              fetch_pc_nxt = fetch_pc + ADDR_W'(1);
            end
            level_after = fifo_level + LW'(push) - LW'(pop);
            if (level_after < DEPTH_L) begin
              state_nxt    = FS_REQ;
              req_addr_nxt = fetch_pc_nxt;
            end else begin
              state_nxt = FS_IDLE;
            end
          end
        end else if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          drop_nxt     = 1'b1;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  fetch_fifo #(
    .DATA_W     (ADDR_W + DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({imem_rsp_data, fetch_pc}),
    .pop       (pop),
    .flush     (flush),
    .level     (fifo_level),
    .head      (head)
  );

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_stall_cnt <= '0;
    else if (!instr_valid && !redirect_valid) perf_stall_cnt <= sat_inc(perf_stall_cnt);
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory and core modelled at transaction level,
// expected FIFO contents kept as a queue of {pc, instr}.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic [2:0]  fifo_level;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .fifo_level     (fifo_level)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] popped[$];
  logic [15:0] exp_pc;
  int          out_cnt;
  logic [15:0] out_addr;
  logic        out_stale;
  logic        pending_stale;
  int          lat;
  int          n_hs;
  int          n_kept;
  int          n_assert;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: account for this cycle's handshakes, advance, then compare.
  task automatic step();
    logic        hs, rsp, redir, pop, stale_req, keep;
    logic [15:0] acc_addr;
    hs        = imem_req_valid && imem_req_ready;
    acc_addr  = imem_req_addr;
    rsp       = imem_rsp_valid;
    redir     = redirect_valid;
    pop       = (mq.size() != 0) && instr_ready;
    stale_req = pending_stale || redir;
    if (hs) begin
      n_hs++;
      check("one_outstanding", 32'(out_cnt), 32'd0);
      if (!stale_req) check("req_addr", 32'(acc_addr), 32'(exp_pc));
    end else if (imem_req_valid && redir) begin
      pending_stale = 1'b1;
    end
    keep = rsp && !out_stale && !redir;
    if (redir) begin
      mq.delete();
      exp_pc = redirect_pc;
      if (out_cnt != 0) out_stale = 1'b1;
    end else begin
      if (pop) begin
        popped.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (keep) begin
        mq.push_back('{out_addr, out_addr ^ 16'hA5A5});
        exp_pc = exp_pc + 16'd1;
        n_kept++;
      end
    end
    @(posedge clk);
    #1;
    if (hs) begin
      out_cnt       = lat;
      out_addr      = acc_addr;
      out_stale     = stale_req;
      pending_stale = 1'b0;
    end else if (out_cnt > 0) begin
      out_cnt--;
    end
    imem_rsp_valid = (out_cnt == 1);
    imem_rsp_data  = imem_rsp_valid ? (out_addr ^ 16'hA5A5) : 16'($urandom);
    check("no_overflow", 32'(mq.size() <= DEPTH), 32'd1);
    check("level", 32'(fifo_level), 32'(mq.size()));
    check("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("head_pc", 32'(instr_pc), 32'(mq[0].pc));
      check("head_data", 32'(instr_data), 32'(mq[0].data));
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0;
    mq.delete();
    popped.delete();
    exp_pc        = 16'h0;
    out_cnt       = 0;
    out_stale     = 1'b0;
    pending_stale = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", 32'(imem_req_addr), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf", perf_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    int k0;
    logic [15:0] a;
    n_assert = 0; n_fail = 0; n_hs = 0; n_kept = 0; lat = 1;

    // 1: streaming from reset, 1-cycle memory, core always ready
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    step(); check("t1_valid_c1", 32'(instr_valid), 32'd0);
    step(); check("t1_valid_c2", 32'(instr_valid), 32'd0);
    step(); check("t1_valid_c3", 32'(instr_valid), 32'd1);
    k0 = n_kept;
    repeat (20) step();
    check("t1_throughput", 32'(n_kept - k0), 32'd10);
    check("t1_pc0", 32'(popped[0]), 32'h0);
    check("t1_pc1", 32'(popped[1]), 32'h1);
    check("t1_pc2", 32'(popped[2]), 32'h2);

    // 2: core stalled, FIFO fills and fetch stops; one pop refills exactly one
    instr_ready = 1'b0;
    repeat (12) step();
    check("t2_full", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_no_req", 32'(imem_req_valid), 32'd0);
    end
    k0 = n_hs;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (6) step();
    check("t2_one_req", 32'(n_hs - k0), 32'd1);
    check("t2_refull", 32'(fifo_level), 32'd4);

    // 3: redirect while waiting on a 3-cycle response
    instr_ready = 1'b1; lat = 3;
    for (int i = 0; i < 30 && out_cnt != 3; i++) step();
    check("t3_in_wait", 32'(out_cnt), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    check("t3_flushed", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 30 && !instr_valid; i++) step();
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_pc", 32'(instr_pc), 32'h0040);

    // 4: redirect while a request is held by req_ready=0
    lat = 1; imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !imem_req_valid; i++) step();
    check("t4_req", 32'(imem_req_valid), 32'd1);
    a = imem_req_addr;
    redirect_valid = 1'b1; redirect_pc = 16'h1234;
    step();
    redirect_valid = 1'b0;
    check("t4_hold_v", 32'(imem_req_valid), 32'd1);
    check("t4_hold_a1", 32'(imem_req_addr), 32'(a));
    step();
    check("t4_hold_a2", 32'(imem_req_addr), 32'(a));
    imem_req_ready = 1'b1;
    step();
    for (int i = 0; i < 10 && !imem_req_valid; i++) step();
    check("t4_new_addr", 32'(imem_req_addr), 32'h1234);
    check("t4_dropped", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    check("t4_pc", 32'(instr_pc), 32'h1234);

    // 5: pc wrap, then redirect + response + pop in one cycle
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    popped.delete();
    for (int i = 0; i < 40 && popped.size() < 3; i++) step();
    check("t5_npop", 32'(popped.size() >= 3), 32'd1);
    if (popped.size() >= 3) begin
      check("t5_pc0", 32'(popped[0]), 32'hFFFE);
      check("t5_pc1", 32'(popped[1]), 32'hFFFF);
      check("t5_pc2", 32'(popped[2]), 32'h0000);
    end
    instr_ready = 1'b0; lat = 3;
    for (int i = 0; i < 40 && !(imem_rsp_valid && fifo_level != 0); i++) step();
    check("t5_setup", 32'(imem_rsp_valid && fifo_level != 0), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 16'h0100; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("t5_level0", 32'(fifo_level), 32'd0);
    check("t5_invalid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 30 && !instr_valid; i++) step();
    check("t5_pc", 32'(instr_pc), 32'h0100);

    // random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 3) != 0;
      lat            = 1 + int'($urandom % 4);
      redirect_valid = ($urandom % 25) == 0;
      redirect_pc    = 16'($urandom);
      step();
    end
    redirect_valid = 1'b0;

`ifdef FETCH_PERF_EN
    // 6a: stall counter with memory never ready
    do_reset();
    repeat (10) step();
    check("t6_perf", perf_stall_cnt, 32'd10);
`endif

    // 6b: asynchronous reset mid-WAIT; the in-flight response must be ignored
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 3;
    for (int i = 0; i < 20 && out_cnt != 3; i++) step();
    check("t6_in_wait", 32'(out_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_arst_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_arst_req_addr", 32'(imem_req_addr), 32'h0);
    check("t6_arst_valid", 32'(instr_valid), 32'd0);
    check("t6_arst_level", 32'(fifo_level), 32'd0);
`ifdef FETCH_PERF_EN
    check("t6_arst_perf", perf_stall_cnt, 32'd0);
`endif
    mq.delete();
    exp_pc = 16'h0; out_stale = 1'b1; pending_stale = 1'b0;
    #1 rst_n = 1'b1;
    imem_req_ready = 1'b0;
    repeat (4) step();
    check("t6_ignored", 32'(fifo_level), 32'd0);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    check("t6_restart_pc", 32'(instr_pc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
